// File: rtl/usb_pkg.sv
// Shared USB transmit-path definitions: packet-type encoding, bit-stuffer
// state encoding and the ones-run length that triggers a stuffed zero.
package usb_pkg;

    typedef enum logic [1:0] {
        PT_IDLE      = 2'b00,
        PT_TOKEN     = 2'b01,
        PT_DATA      = 2'b10,
        PT_HANDSHAKE = 2'b11
    } pkt_type_t;

    localparam int unsigned STUFF_RUN_LEN = 6;
    localparam int unsigned RUN_W         = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS  = 2'b01,
        STUFF = 2'b10
    } bstuff_state_t;

    // A nonzero packet type marks the accompanying bit as valid.
    function automatic logic pt_valid(input logic [1:0] pt);
        return (pt != 2'b00);
    endfunction

endpackage

// File: rtl/usb_bstuff_run_ctr.sv
// Saturating counter of consecutive accepted 1s. clr has priority over inc.
// hit reports that the value being loaded on the coming edge equals RUN_LEN,
// so the owner can enter its stuff state on the same edge that the sixth
// 1 is accepted.
import usb_pkg::*;

module usb_bstuff_run_ctr #(
    parameter int unsigned RUN_LEN = STUFF_RUN_LEN
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] run_nxt_s;

    // Next run value: clear, saturating increment, or hold.
    always_comb begin
        run_nxt_s = run_r;
        if (clr) begin
            run_nxt_s = {RUN_W{1'b0}};
        end else if (inc) begin
            if (run_r == RUN_MAX) begin
                run_nxt_s = RUN_MAX;
            end else begin
                run_nxt_s = run_r + {{(RUN_W-1){1'b0}}, 1'b1};
            end
        end else begin
            run_nxt_s = run_r;
        end
    end

    assign hit = inc && !clr && (run_nxt_s == RUN_MAX);

    // Run register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            run_r <= {RUN_W{1'b0}};
        end else begin
            run_r <= run_nxt_s;
        end
    end

endmodule

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s,
// stalling the packetizer for the inserted cycle. Output bit and type are
// registered (one cycle latency); the stall is a pure decode of the state
// register. Optional macro BSTUFF_STATS_EN adds the stuff_cnt statistics port.
import usb_pkg::*;

module usb_bit_stuffer #(
    parameter int unsigned RUN_LEN = STUFF_RUN_LEN
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       bstr_in,
    input  logic [1:0] bstr_in_ready,
    output logic       bstr_in_stall,
    output logic       bstr_out,
    output logic [1:0] bstr_out_ready
`ifdef BSTUFF_STATS_EN
    ,
    output logic [7:0] stuff_cnt
`endif
);

    bstuff_state_t state_r;
    bstuff_state_t state_nxt_s;
    pkt_type_t     pkt_type_r;
    pkt_type_t     pkt_type_nxt_s;
    logic          bstr_out_r;
    logic          bstr_out_nxt_s;
    logic [1:0]    bstr_out_ready_r;
    logic [1:0]    bstr_out_ready_nxt_s;
    logic          run_clr_s;
    logic          run_inc_s;
    logic          run_hit_s;
    logic          in_valid_s;

    assign in_valid_s = pt_valid(bstr_in_ready);

    usb_bstuff_run_ctr #(
        .RUN_LEN (RUN_LEN)
    ) u_run_ctr (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (run_clr_s),
        .inc   (run_inc_s),
        .hit   (run_hit_s)
    );

    // Next state, next output bit/type and run-counter control.
    always_comb begin
        state_nxt_s          = state_r;
        pkt_type_nxt_s       = pkt_type_r;
        bstr_out_nxt_s       = 1'b0;
        bstr_out_ready_nxt_s = 2'b00;
        run_clr_s            = 1'b0;
        run_inc_s            = 1'b0;
        case (state_r)
            STUFF: begin
                // Inserted zero carries the type of the bit that completed the run,
                // and is emitted even if the packet has already ended.
                bstr_out_nxt_s       = 1'b0;
                bstr_out_ready_nxt_s = pkt_type_r;
                run_clr_s            = 1'b1;
                if (in_valid_s) begin
                    state_nxt_s = PASS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IDLE, PASS: begin
                if (in_valid_s) begin
                    bstr_out_nxt_s       = bstr_in;
                    bstr_out_ready_nxt_s = bstr_in_ready;
                    pkt_type_nxt_s       = pkt_type_t'(bstr_in_ready);
                    if (bstr_in) begin
                        run_inc_s = 1'b1;
                        if (run_hit_s) begin
                            state_nxt_s = STUFF;
                        end else begin
                            state_nxt_s = PASS;
                        end
                    end else begin
                        run_clr_s   = 1'b1;
                        state_nxt_s = PASS;
                    end
                end else begin
                    run_clr_s   = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                run_clr_s   = 1'b1;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, packet type and registered output stage.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r          <= IDLE;
            pkt_type_r       <= PT_IDLE;
            bstr_out_r       <= 1'b0;
            bstr_out_ready_r <= 2'b00;
        end else begin
            state_r          <= state_nxt_s;
            pkt_type_r       <= pkt_type_nxt_s;
            bstr_out_r       <= bstr_out_nxt_s;
            bstr_out_ready_r <= bstr_out_ready_nxt_s;
        end
    end

    assign bstr_out       = bstr_out_r;
    assign bstr_out_ready = bstr_out_ready_r;
    assign bstr_in_stall  = (state_r == STUFF);

`ifdef BSTUFF_STATS_EN
    logic [7:0] stuff_cnt_r;

    // Count inserted zeros per packet; restart on the first bit after idle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stuff_cnt_r <= 8'd0;
        end else if (state_r == STUFF) begin
            if (stuff_cnt_r != 8'hFF) begin
                stuff_cnt_r <= stuff_cnt_r + 8'd1;
            end else begin
                stuff_cnt_r <= stuff_cnt_r;
            end
        end else if ((state_r == IDLE) && in_valid_s) begin
            stuff_cnt_r <= 8'd0;
        end else begin
            stuff_cnt_r <= stuff_cnt_r;
        end
    end

    assign stuff_cnt = stuff_cnt_r;
`endif

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Self-checking bench for usb_bit_stuffer. A reference model expands each
// input packet into the expected stuffed stream; the bench drives bits while
// honouring the stall and compares output/type/stall on every falling edge.
module tb_usb_bit_stuffer;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       bstr_in;
    logic [1:0] bstr_in_ready;
    logic       bstr_in_stall;
    logic       bstr_out;
    logic [1:0] bstr_out_ready;
`ifdef BSTUFF_STATS_EN
    logic [7:0] stuff_cnt;
`endif

    int passed = 0;
    int total  = 0;
    int failed = 0;

    typedef struct packed {
        logic       b;
        logic [1:0] t;
        logic       s;
    } ent_t;

    logic       in_bit [0:63];
    logic [1:0] in_typ [0:63];
    int         n_in;
    ent_t       exp_q [$];

    always #5 clk = ~clk;

    usb_bit_stuffer dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .bstr_in        (bstr_in),
        .bstr_in_ready  (bstr_in_ready),
        .bstr_in_stall  (bstr_in_stall),
        .bstr_out       (bstr_out),
        .bstr_out_ready (bstr_out_ready)
`ifdef BSTUFF_STATS_EN
        ,
        .stuff_cnt      (stuff_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Load a packet: pattern bits written MSB first become transmission order.
    task automatic load(input logic [63:0] pat, input int n, input logic [1:0] t);
        n_in = n;
        for (int k = 0; k < n; k++) begin
            in_bit[k] = pat[n-1-k];
            in_typ[k] = t;
        end
    endtask

    // Reference: after every six 1s in a row, a 0 of the same type follows.
    task automatic build_model(output int n_stuff);
        int run;
        ent_t e;
        run = 0;
        n_stuff = 0;
        exp_q.delete();
        for (int k = 0; k < n_in; k++) begin
            e.b = in_bit[k]; e.t = in_typ[k]; e.s = 1'b0;
            exp_q.push_back(e);
            run = in_bit[k] ? run + 1 : 0;
            if (run == 6) begin
                e.b = 1'b0; e.s = 1'b1;
                exp_q.push_back(e);
                run = 0;
                n_stuff++;
            end
        end
    endtask

    // Drive the loaded packet followed by idle and compare every cycle.
    task automatic send_pkt(input string tag);
        int         i;
        int         n_stuff;
        logic       eb;
        logic [1:0] et;
        logic       es;
        i = 0;
        build_model(n_stuff);
        for (int c = 0; c <= exp_q.size() + 1; c++) begin
            @(negedge clk);
            if (c >= 1 && (c - 1) < exp_q.size()) begin
                eb = exp_q[c-1].b; et = exp_q[c-1].t;
            end else begin
                eb = 1'b0; et = 2'b00;
            end
            es = (c < exp_q.size()) ? exp_q[c].s : 1'b0;
            chk(tag, {28'd0, bstr_in_stall, bstr_out_ready, bstr_out}, {28'd0, es, et, eb});
`ifdef BSTUFF_STATS_EN
            if (c == 1) chk({tag, "_cnt_start"}, {24'd0, stuff_cnt}, 32'd0);
`endif
            if (i < n_in) begin
                bstr_in       = in_bit[i];
                bstr_in_ready = in_typ[i];
                if (!bstr_in_stall) i++;
            end else begin
                bstr_in       = 1'b0;
                bstr_in_ready = 2'b00;
            end
        end
        chk({tag, "_consumed"}, i, n_in);
`ifdef BSTUFF_STATS_EN
        chk({tag, "_cnt_end"}, {24'd0, stuff_cnt}, n_stuff);
`endif
    endtask

    initial begin
        rst_b         = 1'b0;
        bstr_in       = 1'b0;
        bstr_in_ready = 2'b00;
        #12;
        chk("reset", {28'd0, bstr_in_stall, bstr_out_ready, bstr_out}, 32'd0);
`ifdef BSTUFF_STATS_EN
        chk("reset_cnt", {24'd0, stuff_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_b = 1'b1;

        // Sync + token PID: no six-1 runs, pure one-cycle delay.
        load(64'h0196, 16, 2'b01);
        send_pkt("token");

        // Seven 1s: one stuff after the sixth.
        load(64'h7F, 7, 2'b10);
        send_pkt("seven_ones");

        // Twelve 1s: two stuffs, the second trailing after the packet ends.
        load(64'hFFF, 12, 2'b11);
        send_pkt("twelve_ones");

        // Five 1s, a 0, five 1s: the 0 clears the run.
        load(64'h7DF, 11, 2'b10);
        send_pkt("no_stuff");

        // Type change without an idle gap keeps the run going.
        load(64'h3FFF, 14, 2'b01);
        for (int k = 4; k < 14; k++) in_typ[k] = 2'b10;
        send_pkt("type_change");

        // Three runs of six: three stuffs in one packet.
        load(64'h3F7EFD, 22, 2'b10);
        send_pkt("three_runs");

        // Reset asserted while in the stuff cycle.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bstr_in       = 1'b1;
            bstr_in_ready = 2'b10;
        end
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, bstr_in_stall}, 32'd1);
        rst_b = 1'b0;
        #1;
        chk("mid_stuff_rst", {28'd0, bstr_in_stall, bstr_out_ready, bstr_out}, 32'd0);
        bstr_in       = 1'b0;
        bstr_in_ready = 2'b00;
        @(negedge clk);
        chk("rst_held", {28'd0, bstr_in_stall, bstr_out_ready, bstr_out}, 32'd0);
        rst_b = 1'b1;
        load(64'h7F, 7, 2'b11);
        send_pkt("after_rst");

        // Random packets biased toward 1s, some with per-bit type changes.
        for (int r = 0; r < 10; r++) begin
            n_in = $urandom_range(1, 60);
            for (int k = 0; k < n_in; k++) begin
                in_bit[k] = ($urandom_range(0, 4) != 0);
                if (r % 2 == 1 && k > 0 && $urandom_range(0, 7) != 0)
                    in_typ[k] = in_typ[k-1];
                else
                    in_typ[k] = 2'($urandom_range(1, 3));
            end
            send_pkt($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
